recebe_hamming: RTL and testbench
=================================

# recebe_hamming

Serial receiver that sits directly upstream of the Hamming(15,11) corrector. It frames an asynchronous-style serial bit stream, gated by a bit-enable strobe, into 15-bit codewords. Each complete codeword is presented on a one-entry valid/ready output buffer whose data bus drives the corrector's 15-bit `entrada`. Framing errors and buffer overruns are flagged and the affected frame is dropped.

## Interface
- `WIDTH`, default 15, codeword length in bits; fixed at 15 for the corrector, parameterised for bench reuse (range 2..31).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  serial line; idles at 1.
- `bit_en`  in  1  bit strobe; `rx` is sampled only in cycles where `bit_en`=1.
- `codigo`  out  WIDTH  received codeword; bit 0 is the first data bit on the line; connects to corrector `entrada`.
- `codigo_valido`  out  1  `codigo` holds an unconsumed codeword.
- `codigo_pronto`  in  1  consumer accepts `codigo` this cycle.
- `ocupado`  out  1  a frame is in progress (state ≠ OCIOSO).
- `erro_quadro`  out  1  one-cycle pulse: stop bit sampled as 0.
- `estouro`  out  1  one-cycle pulse: valid frame dropped because the buffer was full.

## Operation
- Frame on line: start bit 0, then WIDTH code bits LSB first (codeword bit 0 first), then stop bit 1.
- FSM states: OCIOSO, DADOS, PARADA. Bit counter is ceil(log2(WIDTH)) wide.
  - OCIOSO: on `bit_en` with `rx`=0, go to DADOS and clear the counter. `rx`=1 or `bit_en`=0 means stay.
  - DADOS: on `bit_en`, write `rx` into shift-register bit [counter] and increment the counter. After the sample with counter = WIDTH-1, go to PARADA.
  - PARADA: on `bit_en`, always return to OCIOSO.
    - `rx`=1: the frame is good; attempt to load the buffer.
    - `rx`=0: pulse `erro_quadro` and discard the frame. This 0 is not treated as a new start bit.
- Buffer load on a good frame:
  - Accepted if `codigo_valido`=0, or if `codigo_valido`=1 and `codigo_pronto`=1 in the same cycle (simultaneous drain and load). The new word replaces the old one and `codigo_valido` stays 1.
  - Otherwise pulse `estouro`; the new frame is dropped and the buffer is unchanged.
- Output handshake:
  - A transfer occurs in any cycle with `codigo_valido`=1 and `codigo_pronto`=1.
  - After a transfer with no simultaneous load, `codigo_valido` falls the next cycle.
  - While `codigo_valido`=1 and `codigo_pronto`=0, `codigo` is held stable.
  - `codigo_pronto` is ignored while `codigo_valido`=0.
- The shift register is separate from `codigo`, so reception of the next frame proceeds while the buffer is full.
- `ocupado` is a registered decode of the state: 1 in DADOS and PARADA.

## Timing
- Reset values: state OCIOSO, counter 0, `codigo`=0, `codigo_valido`=0, `ocupado`=0, `erro_quadro`=0, `estouro`=0.
- `rst` has priority over every other input. Reset mid-frame discards the partial frame and clears a held codeword.
- All outputs are registered; there are no combinational input-to-output paths.
- Latency: `codigo_valido` rises in the cycle after the cycle in which the stop bit is sampled with `bit_en`=1.
- `erro_quadro` and `estouro` are asserted in that same following cycle, each for exactly one cycle.
- `ocupado` rises the cycle after the start-bit sample and falls the cycle after the stop-bit sample.
- Cycles with `bit_en`=0 change nothing except the output handshake. Back-to-back `bit_en` (every cycle) is supported.
- A start bit sampled on the `bit_en` immediately after a good stop bit begins a new frame with no idle gap.

## Test plan
- Reset, then frame of 15'h2A5C with `bit_en` every 4th cycle and `codigo_pronto`=1 → `codigo`=15'h2A5C and `codigo_valido` high for 1 cycle, starting the cycle after the stop sample; `ocupado` high for 16 sample periods.
- Frame 15'h7FFF with stop bit 0 → `erro_quadro` pulses once, `codigo_valido` stays 0, FSM returns to OCIOSO. The next good frame 15'h0001 is received correctly.
- `codigo_pronto`=0, frames 15'h1111 then 15'h2222 → `codigo` holds 15'h1111 and `estouro` pulses at the end of the second frame. Then raise `codigo_pronto` → 15'h1111 transferred and `codigo_valido` falls.
- Buffer full with 15'h1111; raise `codigo_pronto` exactly in the stop-sample cycle of frame 15'h3333 → no `estouro`, and `codigo`=15'h3333 with `codigo_valido`=1 on the next cycle.
- Assert `rst` for 1 cycle after 7 data bits of a frame → all outputs 0. Following frame 15'h4567 is received with no residue.
- Back-to-back frames with `bit_en`=1 every cycle, 15'h0000 then 15'h7FFE → both delivered in order, 17 cycles apart.

Source files
------------

// File: rtl/recebe_hamming.sv
// rtl/recebe_hamming.sv - serial frame receiver feeding the Hamming(15,11) corrector
//
// Purpose:
//   Frames a bit-strobed serial line into WIDTH-bit codewords.
//   Each frame on the line is: start bit 0, WIDTH code bits LSB first, stop bit 1.
//   A good frame is loaded into a one-entry valid/ready output buffer.
//   A bad stop bit raises erro_quadro and the frame is dropped.
//   A good frame that finds the buffer full raises estouro and is dropped.
//
// Ports:
//   i_clk             system clock, rising edge
//   i_rst             synchronous active-high reset
//   i_rx              serial line, idles at 1
//   i_bit_en          bit strobe; i_rx is sampled only when this is 1
//   o_codigo          received codeword, bit 0 = first data bit (to corrector entrada)
//   o_codigo_valido   o_codigo holds an unconsumed codeword
//   i_codigo_pronto   consumer accepts o_codigo this cycle
//   o_ocupado         a frame is in progress
//   o_erro_quadro     one-cycle pulse: stop bit sampled as 0
//   o_estouro         one-cycle pulse: good frame dropped, buffer full

module recebe_hamming #(
   parameter int WIDTH = 15
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_rx,
   input  logic             i_bit_en,
   output logic [WIDTH-1:0] o_codigo,
   output logic             o_codigo_valido,
   input  logic             i_codigo_pronto,
   output logic             o_ocupado,
   output logic             o_erro_quadro,
   output logic             o_estouro
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] OCIOSO = 2'd0;
   localparam logic [1:0] DADOS  = 2'd1;
   localparam logic [1:0] PARADA = 2'd2;

   logic [1:0]       r_estado;
   logic [CW-1:0]    r_cont;
   logic [WIDTH-1:0] r_desloc;
   logic [WIDTH-1:0] r_codigo;
   logic             r_valido;
   logic             r_ocupado;
   logic             r_erro;
   logic             r_estouro;

   // The buffer can take a new word if it is empty or being drained this cycle.
   logic w_buf_livre;
   assign w_buf_livre = ~r_valido | i_codigo_pronto;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_estado  <= OCIOSO;
         r_cont    <= '0;
         r_desloc  <= '0;
         r_codigo  <= '0;
         r_valido  <= 1'b0;
         r_ocupado <= 1'b0;
         r_erro    <= 1'b0;
         r_estouro <= 1'b0;
      end else begin
         r_erro    <= 1'b0;
         r_estouro <= 1'b0;

         // Drain; a load in the same cycle below overrides this.
         if (r_valido && i_codigo_pronto)
            r_valido <= 1'b0;

         if (i_bit_en) begin
            case (r_estado)
               OCIOSO: begin
                  if (!i_rx) begin
                     r_estado  <= DADOS;
                     r_cont    <= '0;
                     r_ocupado <= 1'b1;
                  end
               end
               DADOS: begin
                  r_desloc[r_cont] <= i_rx;
                  r_cont           <= r_cont + CW'(1);
                  if (r_cont == CW'(WIDTH - 1))
                     r_estado <= PARADA;
               end
               PARADA: begin
                  // A 0 here is a framing error, never a new start bit.
                  r_estado  <= OCIOSO;
                  r_ocupado <= 1'b0;
                  if (i_rx) begin
                     if (w_buf_livre) begin
                        r_codigo <= r_desloc;
                        r_valido <= 1'b1;
                     end else begin
                        r_estouro <= 1'b1;
                     end
                  end else begin
                     r_erro <= 1'b1;
                  end
               end
               default: begin
                  r_estado  <= OCIOSO;
                  r_ocupado <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_codigo        = r_codigo;
   assign o_codigo_valido = r_valido;
   assign o_ocupado       = r_ocupado;
   assign o_erro_quadro   = r_erro;
   assign o_estouro       = r_estouro;

endmodule

// File: tb/tb_recebe_hamming.sv
// tb/tb_recebe_hamming.sv - directed self-checking bench for recebe_hamming

module tb_recebe_hamming;

   localparam int W = 15;

   logic         i_clk = 1'b0;
   logic         i_rst = 1'b1;
   logic         i_rx = 1'b1;
   logic         i_bit_en = 1'b0;
   logic [W-1:0] o_codigo;
   logic         o_codigo_valido;
   logic         i_codigo_pronto = 1'b0;
   logic         o_ocupado;
   logic         o_erro_quadro;
   logic         o_estouro;

   int n_comp = 0;
   int n_err  = 0;
   int cyc    = 0;
   int ocup_cnt = 0;
   int t1, t2;

   recebe_hamming #(.WIDTH(W)) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_rx            (i_rx),
      .i_bit_en        (i_bit_en),
      .o_codigo        (o_codigo),
      .o_codigo_valido (o_codigo_valido),
      .i_codigo_pronto (i_codigo_pronto),
      .o_ocupado       (o_ocupado),
      .o_erro_quadro   (o_erro_quadro),
      .o_estouro       (o_estouro)
   );

   always #5 i_clk = ~i_clk;

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_comp++;
      if (obs !== esp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
      end
   endtask

   // One clock; afterwards outputs reflect the edge just taken.
   task automatic tick();
      @(posedge i_clk);
      #1;
      cyc++;
      if (o_ocupado) ocup_cnt++;
   endtask

   task automatic envia_bit(input logic b, input int gap);
      i_rx     = b;
      i_bit_en = 1'b1;
      tick();
      i_bit_en = 1'b0;
      i_rx     = 1'b1;
      repeat (gap - 1) tick();
   endtask

   // Start bit plus the WIDTH data bits; the stop bit is sent by the caller.
   task automatic envia_dados(input logic [W-1:0] word, input int gap);
      envia_bit(1'b0, gap);
      for (int i = 0; i < W; i++) envia_bit(word[i], gap);
   endtask

   task automatic envia_parada(input logic b);
      i_rx     = b;
      i_bit_en = 1'b1;
      tick();
      i_bit_en = 1'b0;
      i_rx     = 1'b1;
   endtask

   initial begin
      // Reset state
      tick(); tick();
      verifica("rst_codigo", 32'(o_codigo), 32'h0);
      verifica("rst_valido", 32'(o_codigo_valido), 32'h0);
      verifica("rst_ocupado", 32'(o_ocupado), 32'h0);
      verifica("rst_erro", 32'(o_erro_quadro), 32'h0);
      verifica("rst_estouro", 32'(o_estouro), 32'h0);
      i_rst = 1'b0;
      tick();

      // Frame 2A5C, bit_en every 4th cycle, consumer always ready
      i_codigo_pronto = 1'b1;
      ocup_cnt = 0;
      envia_dados(15'h2A5C, 4);
      envia_parada(1'b1);
      verifica("t1_valido", 32'(o_codigo_valido), 32'h1);
      verifica("t1_codigo", 32'(o_codigo), 32'h2A5C);
      verifica("t1_ocupado_fim", 32'(o_ocupado), 32'h0);
      verifica("t1_ocupado_ciclos", 32'(ocup_cnt), 32'd64);
      tick();
      verifica("t1_valido_1ciclo", 32'(o_codigo_valido), 32'h0);
      repeat (3) tick();

      // Framing error, then a good frame
      envia_dados(15'h7FFF, 4);
      envia_parada(1'b0);
      verifica("t2_erro", 32'(o_erro_quadro), 32'h1);
      verifica("t2_valido", 32'(o_codigo_valido), 32'h0);
      verifica("t2_ocupado", 32'(o_ocupado), 32'h0);
      tick();
      verifica("t2_erro_pulso", 32'(o_erro_quadro), 32'h0);
      envia_dados(15'h0001, 2);
      envia_parada(1'b1);
      verifica("t2_bom_valido", 32'(o_codigo_valido), 32'h1);
      verifica("t2_bom_codigo", 32'(o_codigo), 32'h0001);
      tick();

      // Overrun: buffer held, second frame dropped
      i_codigo_pronto = 1'b0;
      envia_dados(15'h1111, 1);
      envia_parada(1'b1);
      verifica("t3_codigo1", 32'(o_codigo), 32'h1111);
      envia_dados(15'h2222, 1);
      envia_parada(1'b1);
      verifica("t3_estouro", 32'(o_estouro), 32'h1);
      verifica("t3_codigo_mantido", 32'(o_codigo), 32'h1111);
      verifica("t3_valido", 32'(o_codigo_valido), 32'h1);
      tick();
      verifica("t3_estouro_pulso", 32'(o_estouro), 32'h0);
      i_codigo_pronto = 1'b1;
      tick();
      verifica("t3_drenado", 32'(o_codigo_valido), 32'h0);
      i_codigo_pronto = 1'b0;
      tick();

      // Simultaneous drain and load
      envia_dados(15'h1111, 1);
      envia_parada(1'b1);
      verifica("t4_cheio", 32'(o_codigo_valido), 32'h1);
      envia_dados(15'h3333, 1);
      i_codigo_pronto = 1'b1;
      envia_parada(1'b1);
      verifica("t4_sem_estouro", 32'(o_estouro), 32'h0);
      verifica("t4_codigo", 32'(o_codigo), 32'h3333);
      verifica("t4_valido", 32'(o_codigo_valido), 32'h1);
      tick();
      verifica("t4_drenado", 32'(o_codigo_valido), 32'h0);

      // Reset mid-frame, with a held codeword
      i_codigo_pronto = 1'b0;
      envia_dados(15'h1111, 1);
      envia_parada(1'b1);
      envia_bit(1'b0, 1);
      for (int i = 0; i < 7; i++) envia_bit(1'b1, 1);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      verifica("t5_codigo", 32'(o_codigo), 32'h0);
      verifica("t5_valido", 32'(o_codigo_valido), 32'h0);
      verifica("t5_ocupado", 32'(o_ocupado), 32'h0);
      verifica("t5_erro", 32'(o_erro_quadro), 32'h0);
      verifica("t5_estouro", 32'(o_estouro), 32'h0);
      tick();
      i_codigo_pronto = 1'b1;
      envia_dados(15'h4567, 3);
      envia_parada(1'b1);
      verifica("t5_codigo_novo", 32'(o_codigo), 32'h4567);
      verifica("t5_valido_novo", 32'(o_codigo_valido), 32'h1);
      tick();

      // Back-to-back frames, bit_en every cycle
      envia_dados(15'h0000, 1);
      envia_parada(1'b1);
      t1 = cyc;
      verifica("t6_codigo_a", 32'(o_codigo), 32'h0000);
      verifica("t6_valido_a", 32'(o_codigo_valido), 32'h1);
      envia_dados(15'h7FFE, 1);
      envia_parada(1'b1);
      t2 = cyc;
      verifica("t6_codigo_b", 32'(o_codigo), 32'h7FFE);
      verifica("t6_valido_b", 32'(o_codigo_valido), 32'h1);
      verifica("t6_distancia", 32'(t2 - t1), 32'd17);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_err);
      $finish;
   end

endmodule
